// File: rtl/npu_pkg.sv
// Shared constants and types for the conv datapath front end.
package npu_pkg;

  localparam int K_H   = 3;   // kernel height, rows per emitted column
  localparam int IN1_H = 16;  // image rows per frame
  localparam int IN1_W = 15;  // image columns per row
  localparam int PIX_W = 8;   // pixel width in bits

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } feeder_state_t;

endpackage

// File: rtl/line_buf_row.sv
// One image row of pixel storage. The read is combinational so the feeder
// can build a column and shift the row in the same accept cycle.
module line_buf_row #(
  parameter int DEPTH = 15,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: contents are never reset, the fill rows overwrite them.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/conv_col_feeder.sv
// Raster pixel stream to vertical K_H-pixel columns for the conv engine.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start, no pixels accepted
//   S_FILL   | rows 0..K_H-2 stored into the line buffer, nothing emitted
//   S_STREAM | every accepted pixel loads one column into the output register
//   S_DRAIN  | last pixel taken, waiting for the final column handshake
//   S_DONE   | frame_done pulse for one cycle, back to idle
module conv_col_feeder #(
  parameter int K_H   = npu_pkg::K_H,
  parameter int IMG_H = npu_pkg::IN1_H,
  parameter int IMG_W = npu_pkg::IN1_W,
  parameter int DW    = npu_pkg::PIX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K_H*DW-1:0]          out_col,
  output logic [$clog2(IMG_H)-1:0]   out_row_idx,
  output logic [$clog2(IMG_W)-1:0]   out_col_idx,
  output logic                       out_last_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       frame_done
);

  import npu_pkg::*;

  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int NLB = K_H - 1;

  localparam logic [RW-1:0] R_FILL_LAST = RW'(K_H - 2);
  localparam logic [RW-1:0] R_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_OFS       = RW'(K_H - 1);
  localparam logic [CW-1:0] C_LAST      = CW'(IMG_W - 1);

  feeder_state_t state, state_next;

  logic [RW-1:0]       r_cnt;
  logic [CW-1:0]       c_cnt;
  logic                accept;
  logic                row_end;
  logic                frame_end;
  logic [DW-1:0]       lb_rd [NLB];
  logic [K_H*DW-1:0]   col_next;

  // A new pixel is only taken when the output register is free or draining.
  assign in_ready   = ((state == S_FILL) || (state == S_STREAM)) &&
                      (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign row_end    = (c_cnt == C_LAST);
  assign frame_end  = row_end && (r_cnt == R_LAST);
  assign busy       = (state == S_FILL) || (state == S_STREAM) || (state == S_DRAIN);
  assign frame_done = (state == S_DONE);

  // Row buffers form a vertical shift chain per column: lb[0] holds the
  // oldest row, the newest pixel enters at the top.
  for (genvar i = 0; i < NLB; i++) begin : g_lb
    logic [DW-1:0] wdata;
    if (i == NLB - 1) begin : g_top
      assign wdata = in_data;
    end else begin : g_mid
      assign wdata = lb_rd[i+1];
    end

    line_buf_row #(
      .DEPTH (IMG_W),
      .DW    (DW),
      .AW    (CW)
    ) u_row (
      .clk   (clk),
      .we    (accept),
      .widx  (c_cnt),
      .wdata (wdata),
      .ridx  (c_cnt),
      .rdata (lb_rd[i])
    );

    assign col_next[i*DW +: DW] = lb_rd[i];
  end

  assign col_next[NLB*DW +: DW] = in_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FILL;
      S_FILL:   if (accept && row_end && (r_cnt == R_FILL_LAST)) state_next = S_STREAM;
      S_STREAM: if (accept && frame_end) state_next = S_DRAIN;
      S_DRAIN:  if (out_valid && out_ready) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Raster position; frozen on the last pixel so it never runs past the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (accept && !frame_end) begin
      if (row_end) begin
        c_cnt <= '0;
        r_cnt <= r_cnt + RW'(1);
      end else begin
        c_cnt <= c_cnt + CW'(1);
      end
    end
  end

  // Output register: reload on accept (possibly in the same cycle as a
  // handshake), clear valid only when the column leaves with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_col      <= '0;
      out_row_idx  <= '0;
      out_col_idx  <= '0;
      out_last_col <= 1'b0;
      out_last     <= 1'b0;
    end else if (accept && (state == S_STREAM)) begin
      out_valid    <= 1'b1;
      out_col      <= col_next;
      out_row_idx  <= r_cnt - R_OFS;
      out_col_idx  <= c_cnt;
      out_last_col <= row_end;
      out_last     <= frame_end;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_col_feeder.sv
// Directed bench for conv_col_feeder at default geometry (3 x 16 x 15, 8-bit).
module tb_conv_col_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_col;
  logic [3:0]  out_row_idx;
  logic [3:0]  out_col_idx;
  logic        out_last_col;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  conv_col_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_col      (out_col),
    .out_row_idx  (out_row_idx),
    .out_col_idx  (out_col_idx),
    .out_last_col (out_last_col),
    .out_last     (out_last),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Column n of the frame: rows ro, ro+1, ro+2 at column c; pixel(r,c) = (r*15+c) mod 256.
  function automatic logic [23:0] col_exp(input int n);
    int ro;
    int c;
    logic [7:0] b0, b1, b2;
    ro = n / 15;
    c  = n % 15;
    b0 = 8'(ro * 15 + c);
    b1 = 8'((ro + 1) * 15 + c);
    b2 = 8'((ro + 2) * 15 + c);
    return {b2, b1, b0};
  endfunction

  task automatic start_frame();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Streams one frame of pixels and checks every column handshake.
  task automatic run_frame(input int stall_col, input int poke_at, input int abort_at,
                           output int ncol, output int drv_cycles,
                           output logic [23:0] first_col, output logic [23:0] last_col,
                           output logic [3:0] last_row, output logic [3:0] last_cidx,
                           output logic last_flag);
    int pidx = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit rise_seen = 0;
    ncol = 0; drv_cycles = 0;
    first_col = '0; last_col = '0; last_row = '0; last_cidx = '0; last_flag = 1'b0;
    while (!(pidx == 240 && ncol == 210) && cyc < 1000 && pidx != abort_at) begin
      @(posedge clk);
      #1;
      if (!stalled && stall_left == 0 && ncol == stall_col && out_valid) stall_left = 5;
      out_ready = (stall_left == 0);
      in_valid  = (pidx < 240);
      in_data   = 8'(pidx);
      start     = (pidx == poke_at);
      if (in_valid) drv_cycles++;
      #1;
      if (stall_left > 0) begin
        checks++;
        if (out_col !== col_exp(stall_col)) begin
          errors++;
          $display("FAIL bp_hold_col: got %h want %h", out_col, col_exp(stall_col));
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        stall_left--;
        if (stall_left == 0) stalled = 1;
      end
      if (pidx <= 30) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_out_valid: pixel %0d got %b want 0", pidx, out_valid);
        end
      end else if (pidx == 31 && !rise_seen) begin
        rise_seen = 1;
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL fill_rise: got %b want 1", out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (ncol >= 210) begin
          errors++;
          $display("FAIL extra_col: got column %0d want at most 210", ncol + 1);
        end else begin
          if (out_col !== col_exp(ncol)) begin
            errors++;
            $display("FAIL col_data[%0d]: got %h want %h", ncol, out_col, col_exp(ncol));
          end
          checks++;
          if (out_row_idx !== 4'(ncol / 15)) begin
            errors++;
            $display("FAIL row_idx[%0d]: got %0d want %0d", ncol, out_row_idx, ncol / 15);
          end
          checks++;
          if (out_col_idx !== 4'(ncol % 15)) begin
            errors++;
            $display("FAIL col_idx[%0d]: got %0d want %0d", ncol, out_col_idx, ncol % 15);
          end
          checks++;
          if (out_last_col !== (ncol % 15 == 14)) begin
            errors++;
            $display("FAIL last_col[%0d]: got %b want %b", ncol, out_last_col, (ncol % 15 == 14));
          end
          checks++;
          if (out_last !== (ncol == 209)) begin
            errors++;
            $display("FAIL last[%0d]: got %b want %b", ncol, out_last, (ncol == 209));
          end
          if (ncol == 0) first_col = out_col;
          if (ncol == 209) begin
            last_col  = out_col;
            last_row  = out_row_idx;
            last_cidx = out_col_idx;
            last_flag = out_last;
          end
        end
        ncol++;
      end
      if (in_valid && in_ready) pidx++;
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (cyc >= 1000) begin
      errors++;
      $display("FAIL frame_timeout: got %0d pixels %0d columns want 240 and 210", pidx, ncol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    checks++; if (out_col !== 24'h0)    begin errors++; $display("FAIL rst_out_col: got %h want 0", out_col); end
    checks++; if (out_row_idx !== 4'd0) begin errors++; $display("FAIL rst_row_idx: got %0d want 0", out_row_idx); end
    checks++; if (out_col_idx !== 4'd0) begin errors++; $display("FAIL rst_col_idx: got %0d want 0", out_col_idx); end
    checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
    checks++; if (out_last_col !== 1'b0) begin errors++; $display("FAIL rst_last_col: got %b want 0", out_last_col); end
    rst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_ready: cycle %0d got %b want 0", i, in_ready);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int ncol, drv;
    logic [23:0] fc, lc;
    logic [3:0] lr, lci;
    logic lf;
    start_frame();
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    run_frame(-1, -1, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++; if (drv !== 240)        begin errors++; $display("FAIL throughput: got %0d cycles want 240", drv); end
    checks++; if (ncol !== 210)       begin errors++; $display("FAIL col_count: got %0d want 210", ncol); end
    checks++; if (fc !== 24'h1E0F00)  begin errors++; $display("FAIL first_col: got %h want 1e0f00", fc); end
    checks++; if (lc !== 24'hEFE0D1)  begin errors++; $display("FAIL last_col_data: got %h want efe0d1", lc); end
    checks++; if (lr !== 4'd13)       begin errors++; $display("FAIL last_row_idx: got %0d want 13", lr); end
    checks++; if (lci !== 4'd14)      begin errors++; $display("FAIL last_col_idx: got %0d want 14", lci); end
    checks++; if (lf !== 1'b1)        begin errors++; $display("FAIL last_flag: got %b want 1", lf); end
  endtask

  task automatic test_backpressure();
    int ncol, drv;
    logic [23:0] fc, lc;
    logic [3:0] lr, lci;
    logic lf;
    start_frame();
    run_frame(3, -1, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++; if (ncol !== 210)       begin errors++; $display("FAIL bp_col_count: got %0d want 210", ncol); end
    checks++; if (lc !== 24'hEFE0D1)  begin errors++; $display("FAIL bp_last_col: got %h want efe0d1", lc); end
  endtask

  task automatic test_frame_end();
    int ncol, drv;
    logic [23:0] fc, lc;
    logic [3:0] lr, lci;
    logic lf;
    int pulses = 0;
    start_frame();
    run_frame(-1, -1, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_state: got busy=%b done=%b want busy=1 done=0", busy, frame_done);
    end
    @(posedge clk); #2;
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", frame_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", busy); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      if (frame_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL done_extra: got %0d extra pulses want 0", pulses); end
    start_frame();
    run_frame(-1, -1, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++;
    if (fc !== 24'h1E0F00) begin errors++; $display("FAIL restart_first_col: got %h want 1e0f00", fc); end
  endtask

  task automatic test_start_mid_frame();
    int ncol, drv;
    logic [23:0] fc, lc;
    logic [3:0] lr, lci;
    logic lf;
    start_frame();
    run_frame(-1, 100, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++; if (ncol !== 210) begin errors++; $display("FAIL poke_col_count: got %0d want 210", ncol); end
    checks++; if (drv !== 240)  begin errors++; $display("FAIL poke_throughput: got %0d want 240", drv); end
  endtask

  task automatic test_mid_reset();
    int ncol, drv;
    logic [23:0] fc, lc;
    logic [3:0] lr, lci;
    logic lf;
    start_frame();
    run_frame(-1, -1, 110, ncol, drv, fc, lc, lr, lci, lf);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL mrst_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
    start_frame();
    run_frame(-1, -1, -1, ncol, drv, fc, lc, lr, lci, lf);
    checks++; if (ncol !== 210)      begin errors++; $display("FAIL mrst_col_count: got %0d want 210", ncol); end
    checks++; if (fc !== 24'h1E0F00) begin errors++; $display("FAIL mrst_first_col: got %h want 1e0f00", fc); end
    checks++; if (lc !== 24'hEFE0D1) begin errors++; $display("FAIL mrst_last_col: got %h want efe0d1", lc); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_frame();
    test_backpressure();
    test_frame_end();
    test_start_mid_frame();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_col_feeder.md
Name: conv_col_feeder

Overview:
Upstream stage of the conv datapath. It accepts an image as a raster-order pixel stream (one byte per beat, valid/ready) and buffers K_H-1 previous rows. It emits one vertical K_H-pixel column per accepted pixel once enough rows are present. Each column is packed in the same byte order the conv engine's image column load expects (byte0 = oldest row), so column loads no longer need per-column host writes.

Parameters:
K_H, 3, kernel height (rows per emitted column)
IMG_H, 16, image rows per frame
IMG_W, 15, image columns per row
DW, 8, pixel width in bits

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a frame when idle
in_valid  in  1  pixel present
in_data  in  DW  pixel, raster order (row-major, col 0 first)
in_ready  out  1  pixel accepted when in_valid & in_ready
out_valid  out  1  column present
out_ready  in  1  consumer accepts column
out_col  out  K_H*DW  column; [DW-1:0]=row r-K_H+1 ... top byte = row r
out_row_idx  out  $clog2(IMG_H)  output row (r-(K_H-1))
out_col_idx  out  $clog2(IMG_W)  column c
out_last_col  out  1  c==IMG_W-1
out_last  out  1  last column of frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-frame): state=S_IDLE, counters 0. in_ready, out_valid, out_last_col, out_last, busy and frame_done are 0; out_col, out_row_idx and out_col_idx are 0. Line-buffer contents are not cleared; S_FILL rewrites them.
- States:
  - S_IDLE: start -> S_FILL, busy=1.
  - S_FILL: rows 0..K_H-2; pixels are stored, nothing is emitted; after the last pixel of row K_H-2 -> S_STREAM.
  - S_STREAM: rows K_H-1..IMG_H-1; each accepted pixel loads the output register.
  - S_DRAIN: entered after the last pixel of the frame is accepted; waits for the final out handshake, then -> S_DONE.
  - S_DONE: frame_done=1 for exactly one cycle, busy=0 -> S_IDLE.
- in_ready = (S_FILL | S_STREAM) & (~out_valid | out_ready). In S_IDLE, S_DRAIN and S_DONE, in_ready=0 and in_valid is ignored.
- Line buffer: K_H-1 arrays lb[0..K_H-2], each IMG_W x DW. On accept at column c with pixel p:
  - column = {p, lb[K_H-2][c], ..., lb[0][c]};
  - lb[i][c] <= lb[i+1][c] for i < K_H-2, and lb[K_H-2][c] <= p.
- Latency: pixel accept in S_STREAM -> out_valid=1 on the next cycle with registered column and indices.
- Output hold: while out_valid & ~out_ready, out_col and all out_* fields stay stable and in_ready=0.
- out_valid clears only on handshake with no simultaneous accept. Handshake plus a simultaneous accept reloads the output register in the same cycle, giving full throughput of 1 column/cycle.
- Counters:
  - c increments per accept and wraps IMG_W-1 -> 0.
  - r increments on c wrap.
  - The last pixel (r=IMG_H-1, c=IMG_W-1) moves to S_DRAIN; r and c are not advanced past the frame.
- Output count per frame = (IMG_H-K_H+1)*IMG_W (210 at defaults). out_last is asserted only on the final column.
- start while busy is ignored.
- No arithmetic is performed; data is passed through unsigned.

Decomposition:
- Shared package npu_pkg: frame/kernel constants (K_H, IN1_H, IN1_W), pixel width, and feeder state enum typedef.
- One sub-module, line_buf_row: a single IMG_W x DW row memory with write-enable, write/read index and registered-free read. It is instantiated K_H-1 times.

Test Plan:
- Full frame, pixel(r,c)=(r*15+c)&0xFF, in_valid and out_ready held at 1:
  - 240 accepts in 240 consecutive cycles;
  - exactly 210 columns;
  - first column out_col=0x1E0F00 (row_idx 0, col_idx 0);
  - last column out_col=0xEFE0D1 with out_last=1, row_idx=13, col_idx=14.
- Fill phase: first 30 accepted pixels produce out_valid=0 throughout; out_valid rises the cycle after the 31st accept.
- Backpressure: drop out_ready for 5 cycles while column 3 is valid:
  - out_col is stable and in_ready=0 for those 5 cycles;
  - no column is lost or duplicated, and the sequence continues at column 4.
- Frame end: after the last column handshake, frame_done pulses exactly once and busy falls with it. A later start begins a new frame whose first column again equals 0x1E0F00.
- Reset mid-frame at row 7: on the next cycle out_valid=0, in_ready=0 and busy=0. A fresh start and full frame reproduce the scenario-1 outputs exactly.
- Ignored inputs:
  - start pulsed mid-frame has no effect on counters or output;
  - in_valid asserted in S_IDLE is not accepted (in_ready=0).
